// File: rtl/timer_clk_prescaler.sv
// Counting-clock prescaler: power-of-two or linear divide, glitch-free config load at wrap,
// with halt/restart. Produces a square clk_cnt and a one-cycle tick, both on pclk.
module timer_clk_prescaler #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             pclk_i,
    input  logic             preset_i,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic [SEL_W-1:0] div_sel_i,
    input  logic [CNT_W-1:0] div_val_i,
    input  logic             halt_i,
    input  logic             restart_i,
    output logic             clk_cnt_o,
    output logic             tick_o,
    output logic             cfg_busy_o
);

    logic [CNT_W:0]   dreq;
    logic [CNT_W:0]   div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             wrap;
    int unsigned      sel_exp;

    // Requested divisor, one bit wider than the counter so 2^CNT_W is representable.
    always_comb begin
        sel_exp = int'(div_sel_i) + 1;
        if (mode_i) begin
            dreq = {1'b0, div_val_i} + (CNT_W+1)'(1);
        end else if (sel_exp > CNT_W) begin
            dreq = (CNT_W+1)'(1) << CNT_W;
        end else begin
            dreq = (CNT_W+1)'(1) << sel_exp;
        end
    end

    assign wrap = ({1'b0, cnt_q} == (div_q - (CNT_W+1)'(1)));

    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (!en_i || restart_i) begin
            div_d = dreq;
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (!halt_i) begin
            if (wrap) begin
                cnt_d = '0;
                div_d = dreq;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Duty is derived from the divisor that applies to the new count value.
            clk_d  = ({1'b0, cnt_d} >= (div_d >> 1));
            tick_d = wrap;
        end
        busy_d = en_i & (dreq != div_d);
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            div_q  <= (CNT_W+1)'(2);
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            busy_q <= busy_d;
        end
    end

    assign clk_cnt_o  = clk_q;
    assign tick_o     = tick_q;
    assign cfg_busy_o = busy_q;

endmodule

// File: tb/tb_timer_clk_prescaler.sv
// Directed bench for timer_clk_prescaler: period, duty, halt, restart, en and reset behaviour.
module tb_timer_clk_prescaler;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  div_sel = '0;
    logic [15:0] div_val = '0;
    logic        halt = 1'b0;
    logic        restart = 1'b0;
    logic        clk_cnt, tick, cfg_busy;

    int checks = 0;
    int failures = 0;

    timer_clk_prescaler #(.SEL_W(3), .CNT_W(16)) dut (
        .pclk_i     (pclk),
        .preset_i   (preset),
        .en_i       (en),
        .mode_i     (mode),
        .div_sel_i  (div_sel),
        .div_val_i  (div_val),
        .halt_i     (halt),
        .restart_i  (restart),
        .clk_cnt_o  (clk_cnt),
        .tick_o     (tick),
        .cfg_busy_o (cfg_busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edges until clk_cnt goes 0->1; also counts ticks seen. n=-1 on timeout.
    task automatic wait_rise(input int limit, output int n, output int ticks);
        logic prev;
        prev  = clk_cnt;
        n     = -1;
        ticks = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge pclk);
            if (tick) ticks++;
            if (!prev && clk_cnt) begin
                n = k;
                break;
            end
            prev = clk_cnt;
        end
    endtask

    task automatic wait_level(input logic val, input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge pclk);
            if (clk_cnt == val) begin
                n = k;
                break;
            end
        end
    endtask

    // Edges until tick; busy counts samples with cfg_busy high on the way.
    task automatic wait_tick(input int limit, output int n, output int busy);
        n    = -1;
        busy = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge pclk);
            if (cfg_busy) busy++;
            if (tick) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge pclk);
        restart = 1'b0;
    endtask

    initial begin
        int n, t, b, cntok;

        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        chk("rst_clk", int'(clk_cnt), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(cfg_busy), 0);

        // div_val is ignored in power-of-two mode
        en = 1'b1;
        div_val = 16'd123;
        @(negedge pclk);
        chk("divval_mode0_busy", int'(cfg_busy), 0);

        for (int s = 0; s < 4; s++) begin
            div_sel = 3'(s);
            do_restart();
            wait_rise(100, n, t);
            chk($sformatf("sweep%0d_first", s), n, (2 << s) / 2);
            wait_rise(100, n, t);
            chk($sformatf("sweep%0d_period", s), n, 2 << s);
            chk($sformatf("sweep%0d_ticks", s), t, 1);
        end

        mode = 1'b1;
        div_val = 16'd4;
        do_restart();
        wait_rise(100, n, t);
        chk("lin5_first_low", n, 2);
        wait_level(1'b0, 100, n);
        chk("lin5_high", n, 3);
        wait_rise(100, n, t);
        chk("lin5_low", n, 2);
        wait_tick(100, n, b);
        wait_tick(100, n, b);
        chk("lin5_tick_period", n, 5);

        div_val = 16'd0;
        do_restart();
        cntok = 0;
        repeat (8) begin
            @(negedge pclk);
            if (tick && clk_cnt) cntok++;
        end
        chk("d1_tick_and_clk_high", cntok, 8);

        div_val = 16'hFFFF;
        do_restart();
        wait_rise(70000, n, t);
        chk("d65536_first_rise", n, 32768);
        wait_tick(70000, n, b);
        chk("d65536_tick_after_rise", n, 32768);

        // config change at cnt=3 of a 16-cycle period
        mode = 1'b0;
        div_sel = 3'd3;
        do_restart();
        repeat (3) @(negedge pclk);
        div_sel = 3'd0;
        wait_tick(100, n, b);
        chk("cfg_old_rate_tick", n, 13);
        chk("cfg_busy_cycles", b, 12);
        wait_rise(100, n, t);
        wait_rise(100, n, t);
        chk("cfg_new_period", n, 2);
        chk("cfg_busy_after", int'(cfg_busy), 0);

        div_sel = 3'd2;
        do_restart();
        repeat (2) @(negedge pclk);
        halt = 1'b1;
        cntok = 0;
        repeat (5) begin
            @(negedge pclk);
            if (tick) cntok++;
        end
        halt = 1'b0;
        chk("halt_no_tick", cntok, 0);
        wait_tick(100, n, b);
        chk("halt_stretched_period", 2 + 5 + n, 13);
        wait_tick(100, n, b);
        chk("halt_next_period", n, 8);

        repeat (5) @(negedge pclk);
        chk("restart_pre_clk", int'(clk_cnt), 1);
        do_restart();
        chk("restart_clk", int'(clk_cnt), 0);
        chk("restart_tick", int'(tick), 0);
        wait_tick(100, n, b);
        chk("restart_next_tick", n, 8);

        repeat (5) @(negedge pclk);
        chk("endrop_pre_clk", int'(clk_cnt), 1);
        en = 1'b0;
        @(negedge pclk);
        chk("endrop_clk", int'(clk_cnt), 0);
        chk("endrop_tick", int'(tick), 0);
        chk("endrop_busy", int'(cfg_busy), 0);
        en = 1'b1;
        wait_rise(100, n, t);
        chk("enrise_first_rise", n, 4);
        wait_rise(100, n, t);
        chk("enrise_period", n, 8);

        div_sel = 3'd3;
        do_restart();
        repeat (8) @(negedge pclk);
        chk("rstmid_pre_clk", int'(clk_cnt), 1);
        #2 preset = 1'b1;
        #1;
        chk("rstmid_clk", int'(clk_cnt), 0);
        chk("rstmid_tick", int'(tick), 0);
        chk("rstmid_busy", int'(cfg_busy), 0);
        chk("rstmid_div", int'(dut.div_q), 2);
        div_sel = 3'd0;
        @(negedge pclk);
        preset = 1'b0;
        wait_rise(100, n, t);
        wait_rise(100, n, t);
        chk("rstmid_after_period", n, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_clk_prescaler.md
# timer_clk_prescaler

Parametrised counting-clock generator for the timer IP. It sits between the APB register block and the timer counter core, and replaces the fixed divide-by-2/4/8/16 select. It has two divide modes: power-of-two and linear divide-by-(N+1). Configuration changes are applied glitch-free at period boundaries, and the block adds halt and restart controls. It produces a square counting clock `clk_cnt` plus a single-cycle `tick` enable, both synchronous to `pclk`.

## Interface
- `SEL_W`, 3: width of the power-of-two select. Divisor is 2^(div_sel+1).
- `CNT_W`, 16: prescale counter width. Also the width of `div_val`.
- `pclk`  in  1  system/APB clock; the only clock.
- `preset`  in  1  asynchronous, active-high reset.
- `en`  in  1  prescaler enable, from TCR.
- `mode`  in  1  0 = power-of-two (`div_sel`), 1 = linear (`div_val`).
- `div_sel`  in  SEL_W  power-of-two select.
- `div_val`  in  CNT_W  linear divisor minus one.
- `halt`  in  1  debug freeze.
- `restart`  in  1  single-cycle pulse; resynchronise the period.
- `clk_cnt`  out  1  divided counting clock, registered.
- `tick`  out  1  one-cycle pulse per period, registered.
- `cfg_busy`  out  1  new config is pending and not yet applied.

## Operation
- **Requested divisor Dreq**
  - mode 0: Dreq = 2^(div_sel+1).
  - If div_sel+1 > CNT_W, clamp to 2^CNT_W.
  - mode 1: Dreq = div_val+1, range 1..2^CNT_W.
  - Internal arithmetic uses CNT_W+1 bits.
- **Active divisor D**
  - Registered copy of Dreq.
  - Loaded on reset, while en=0, on `restart`, and at period wrap only.
- **Counter `cnt`** (CNT_W bits)
  - On each edge with en=1 and halt=0: cnt <= (cnt==D-1) ? 0 : cnt+1.
  - At the wrap edge, D <= Dreq, and `clk_cnt` is computed with the new D.
- **Output `clk_cnt`**
  - clk_cnt <= (cnt_next >= floor(Dnext/2)).
  - Low for floor(D/2) cycles, high for ceil(D/2) cycles.
  - Rising edges are exactly D cycles apart.
  - D=1: clk_cnt is held 1 and `tick` is the only period indicator.
- **Output `tick`**
  - tick <= en & ~halt & (cnt==D-1).
  - Coincides with cnt returning to 0.
- **`en`=0**
  - cnt=0, clk_cnt=0, tick=0, D tracks Dreq.
  - On the en 0→1 edge, counting starts from cnt=0.
- **`halt`=1**
  - cnt, clk_cnt and D are frozen, and tick=0.
  - On release, counting resumes from the frozen state, so the current period is stretched by the halt length.
- **`restart`**
  - Sets cnt=0, clk_cnt=0, tick=0 and D=Dreq on the next edge.
  - Takes priority over halt and wrap. It is ignored when en=0.
- **Output `cfg_busy`**
  - Registered: en & (Dreq != D).
  - Clears on the edge where the pending config is loaded.
- **Simultaneous events**
  - Priority order: reset > en=0 > restart > halt > count.
  - A config change at the same edge as a wrap is loaded at that wrap.

## Timing
- Reset (async assert, release synchronous to `pclk`): cnt=0, D=2 (div_sel=0, mode=0 equivalent), clk_cnt=0, tick=0, cfg_busy=0.
- All outputs are registered; there is no combinational input-to-output path.
- Latency from the en 0→1 edge:
  - first clk_cnt rise after floor(D/2) edges;
  - first tick after D edges.
- A config write with en=1 takes effect at the next wrap. Worst case is the old D cycles later.
- `cfg_busy` rises one edge after Dreq changes.
- Reset mid-period aborts the period immediately with no glitch on clk_cnt.
- If Dreq changes again before the wrap, only the last value is applied.
- `div_val` changing while `mode`=0 has no effect.

## Test plan
- **Power-of-two sweep.** en=1, mode=0, div_sel=0,1,2,3 in turn, each with restart. Required: pclk cycles between consecutive clk_cnt rises = 2, 4, 8, 16; one tick per period.
- **Linear and extremes.**
  - mode=1, div_val=4: clk_cnt low 2 cycles, high 3 cycles, tick every 5 cycles.
  - div_val=0: tick every cycle, clk_cnt held 1.
  - div_val=16'hFFFF: period 65536.
- **Config change mid-period.**
  - Setup: D=16; change div_sel to 0 at cnt=3.
  - Required: the remaining 12 cycles run at the old rate and cfg_busy is high until the wrap.
  - Afterwards: period 2 and cfg_busy=0.
- **Halt.** D=8; halt for 5 cycles at cnt=2. Required: that period measures 13 cycles, no tick during halt, the next period measures 8.
- **Restart and en.**
  - restart at cnt=5 with D=8: cnt=0 and clk_cnt=0 next edge, next tick 8 cycles later.
  - en drop: outputs 0 on the next edge.
  - en re-raised: first rise after 4 cycles.
- **Reset mid-operation.**
  - Assert preset asynchronously between edges with D=16 and clk_cnt=1: all outputs go 0 immediately and D=2.
  - After release with en=1, mode=0, div_sel=0: period is 2.
